pcileech_mux_rr: RTL and testbench
==================================

PCILEECH_MUX_RR -- requirements
Module: pcileech_mux_rr

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, meaning the number of input ports (legal range 1..4).
REQ-002 The block SHALL have parameter WORDS, default 7, meaning the number of 32-bit data words per frame (legal range 1..7).
REQ-003 The block SHALL have parameter TIMEOUT, default 8, meaning the idle cycles before filler insertion into a partial frame (legal range 1..15).
REQ-004 The block SHALL have parameter RR_MODE, default 1, selecting arbitration: 0 = fixed priority with lowest index winning, 1 = round-robin.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port dout, output, 32*(WORDS+1) bits: the frame, with data words in [32*WORDS-1:0] and the status word in the top 32 bits.
REQ-008 The block SHALL have port valid, output, 1 bit: single-cycle qualifier for dout.
REQ-009 The block SHALL have port rd_en, input, 1 bit: downstream can accept; it gates new data requests.
REQ-010 The block SHALL have port din, input, 32*NUM_PORTS bits: port i data in slice [32i+31:32i].
REQ-011 The block SHALL have port ctx, input, 2*NUM_PORTS bits: port i context in slice [2i+1:2i].
REQ-012 The block SHALL have port wr_en, input, NUM_PORTS bits: port i presents a word this cycle.
REQ-013 The block SHALL have port has_data, input, NUM_PORTS bits: port i has pending words.
REQ-014 The block SHALL have port req_data, output, NUM_PORTS bits: registered one-hot (or zero) request to the ports.
REQ-015 The block SHALL have port collision, output, 1 bit: sticky flag, set when more than one wr_en bit is high in the same cycle.

Function
REQ-016 req_data SHALL be registered each cycle as follows: all zero when rd_en=0; otherwise one-hot for the winner among the has_data bits.
REQ-017 In RR_MODE=0 the winner SHALL be the lowest asserted has_data index.
REQ-018 In RR_MODE=1 the winner SHALL be the first asserted has_data index at or after pointer ptr, wrapping modulo NUM_PORTS.
REQ-019 In RR_MODE=1, ptr SHALL load winner+1 (mod NUM_PORTS) in every cycle a request is issued, and SHALL hold otherwise.
REQ-020 Per cycle, the accepted word SHALL be from the lowest index with wr_en=1; on multiple wr_en, higher-index words are dropped and collision is set.
REQ-021 An accepted word SHALL shift into the data register at [31:0] (older words shift up by 32 bits), and SHALL shift tag {ctx[1:0], port[1:0]} into the status register nibble 0 (older nibbles shift up by 4 bits).
REQ-022 The word counter SHALL increment on each accepted or filler word, range 0..WORDS-1.
REQ-023 On the word making the count WORDS, the counter SHALL go to 0, the frame SHALL complete, and the idle counter SHALL be cleared.
REQ-024 At frame completion cycle t, dout and valid=1 SHALL be driven at t+1 (1-cycle latency); otherwise valid=0 and dout holds.
REQ-025 dout status layout SHALL be: nibble k (k<WORDS) = tag of data word k (0 = newest); nibbles WORDS..6 = 4'hF; nibble 7 = 4'hE.
REQ-026 The idle counter SHALL increment, saturating at 15, on cycles where the word counter >0 and no word is accepted.
REQ-027 When the word counter >0, no wr_en is high, and the idle counter >=TIMEOUT, the block SHALL insert a filler word: data 32'hFFFFFFFF, tag 4'hF.
REQ-028 Filler SHALL repeat every cycle until the frame completes; a real word arriving mid-filler SHALL be accepted instead, with no filler that cycle.
REQ-029 When the word counter =0 the idle counter SHALL be 0, so no filler is inserted and no empty frame is produced.
REQ-030 rd_en=0 SHALL NOT block acceptance of already-requested wr_en words or frame emission.
REQ-031 When NUM_PORTS=1, the arbiter SHALL degenerate to req_data[0] <= rd_en & has_data[0].

Reset
REQ-032 On rst=1, asynchronously: valid=0, req_data=0, collision=0, dout=0, word and idle counters=0, ptr=0, data register=0, status register=all F.
REQ-033 Reset mid-frame SHALL discard the partial frame; the first valid after reset release SHALL contain only post-reset words.

Verification
REQ-034 Defaults: port1 writes 7 words 0x1..0x7 with ctx=2 -> one valid pulse; dout[31:0]=0x7, dout[223:192]=0x1; every status nibble 0..6 = 4'h9, nibble 7 = 4'hE.
REQ-035 RR_MODE=1, has_data=4'b1111, rd_en=1 held -> req_data sequence 0001, 0010, 0100, 1000, 0001; with RR_MODE=0 -> 0001 every cycle.
REQ-036 Port0 writes 3 words then goes idle, TIMEOUT=8 -> 4 filler words inserted after 8 idle cycles; valid with dout[127:0]=all F and status nibbles 0..3 = F.
REQ-037 wr_en=4'b0110 in one cycle -> the port1 word is accepted, the port2 word is dropped, collision=1 until rst.
REQ-038 WORDS=3: 3 words from port3, ctx=0 -> 128-bit dout, status nibbles 0..2 = 4'h3, nibbles 3..6 = 4'hF, nibble 7 = 4'hE.
REQ-039 rst pulsed after 4 words, then 7 fresh words -> exactly one valid, containing only the fresh 7 words.

Source files
------------

// File: rtl/pcileech_mux_rr.sv
// Arbitrates up to four word ports into WORDS-word frames with a tag status word; pads partial frames with filler after TIMEOUT idle cycles.
// Frame out one cycle after its last word; rd_en only gates new requests, never acceptance or emission.
module pcileech_mux_rr #(
  parameter int NUM_PORTS = 4,
  parameter int WORDS     = 7,
  parameter int TIMEOUT   = 8,
  parameter int RR_MODE   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [32*(WORDS+1)-1:0] dout,
  output logic                    valid,
  input  logic                    rd_en,
  input  logic [32*NUM_PORTS-1:0] din,
  input  logic [2*NUM_PORTS-1:0]  ctx,
  input  logic [NUM_PORTS-1:0]    wr_en,
  input  logic [NUM_PORTS-1:0]    has_data,
  output logic [NUM_PORTS-1:0]    req_data,
  output logic                    collision
);
  localparam int DW = 32*WORDS;

  logic [DW-1:0]        r_data;
  logic [31:0]          r_stat;
  logic [2:0]           r_wcnt;
  logic [3:0]           r_idle;
  logic [1:0]           r_ptr;
  logic [NUM_PORTS-1:0] r_req;
  logic                 r_valid;
  logic                 r_coll;
  logic [DW+31:0]       r_dout;

  // Ports are widened to four lanes so all indexing below is fixed-width.
  logic [3:0]       w_hd4;
  logic [3:0]       w_wr4;
  logic [3:0][31:0] w_din4;
  logic [3:0][1:0]  w_ctx4;

  assign w_hd4  = 4'(has_data);
  assign w_wr4  = 4'(wr_en);
  assign w_din4 = 128'(din);
  assign w_ctx4 = 8'(ctx);

  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_grant;
  logic [1:0] w_ptr_nxt;
  logic [3:0] w_req4;

  // Scan from the far end so the candidate closest to the start point is kept last.
  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_grant = 1'b0;
    for (int o = NUM_PORTS-1; o >= 0; o--) begin
      w_idx = (RR_MODE != 0) ? 2'((int'(r_ptr) + o) % NUM_PORTS) : 2'(o);
      if (w_hd4[w_idx]) begin
        w_win   = w_idx;
        w_grant = rd_en;
      end
    end
  end

  assign w_ptr_nxt = (w_win == 2'(NUM_PORTS-1)) ? 2'd0 : w_win + 2'd1;
  assign w_req4    = w_grant ? (4'd1 << w_win) : 4'd0;

  logic [1:0]    w_sel;
  logic          w_acc;
  logic          w_multi;
  logic          w_fill;
  logic          w_push;
  logic          w_last;
  logic [31:0]   w_word;
  logic [3:0]    w_tag;
  logic [DW-1:0] w_data_nxt;
  logic [31:0]   w_stat_nxt;
  logic [31:0]   w_stat_out;

  always_comb begin
    w_sel = '0;
    for (int k = 3; k >= 0; k--) begin
      if (w_wr4[k]) w_sel = 2'(k);
    end
  end

  assign w_acc      = |w_wr4;
  assign w_multi    = (w_wr4 & (w_wr4 - 4'd1)) != 4'd0;
  assign w_fill     = (r_wcnt != 3'd0) && !w_acc && (r_idle >= 4'(TIMEOUT));
  assign w_push     = w_acc || w_fill;
  assign w_last     = w_push && (r_wcnt == 3'(WORDS-1));
  assign w_word     = w_acc ? w_din4[w_sel] : 32'hFFFF_FFFF;
  assign w_tag      = w_acc ? {w_ctx4[w_sel], w_sel} : 4'hF;
  assign w_data_nxt = DW'({r_data, w_word});
  assign w_stat_nxt = {r_stat[27:0], w_tag};

  // Nibbles beyond the frame length read as F, top nibble is the frame marker.
  always_comb begin
    w_stat_out = 32'hEFFF_FFFF;
    for (int k = 0; k < WORDS; k++) begin
      w_stat_out[4*k +: 4] = w_stat_nxt[4*k +: 4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req <= '0;
      r_ptr <= '0;
    end else begin
      r_req <= w_req4[NUM_PORTS-1:0];
      if (w_grant) r_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_stat  <= '1;
      r_wcnt  <= '0;
      r_idle  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_coll  <= 1'b0;
    end else begin
      r_valid <= w_last;
      r_coll  <= r_coll | w_multi;
      if (w_push) begin
        r_data <= w_data_nxt;
        r_stat <= w_stat_nxt;
        r_wcnt <= w_last ? 3'd0 : r_wcnt + 3'd1;
      end
      // Idle time only accumulates inside a partial frame; it is not reset by late words.
      if (w_last || r_wcnt == 3'd0) r_idle <= 4'd0;
      else if (!w_acc && r_idle != 4'hF) r_idle <= r_idle + 4'd1;
      if (w_last) r_dout <= {w_stat_out, w_data_nxt};
    end
  end

  assign dout      = r_dout;
  assign valid     = r_valid;
  assign req_data  = r_req;
  assign collision = r_coll;
endmodule

// File: tb/tb_pcileech_mux_rr.sv
module tb_pcileech_mux_rr;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_en = 1'b0;
  logic [127:0] din = '0;
  logic [7:0]   ctx = '0;
  logic [3:0]   wr_en = '0;
  logic [3:0]   has_data = '0;

  logic [255:0] d0, d1;
  logic [127:0] d2;
  logic         v0, v1, v2, c0, c1, c2;
  logic [3:0]   q0, q1, q2;

  always #5 clk = ~clk;

  pcileech_mux_rr u_rr (.clk(clk), .rst(rst), .dout(d0), .valid(v0), .rd_en(rd_en), .din(din),
    .ctx(ctx), .wr_en(wr_en), .has_data(has_data), .req_data(q0), .collision(c0));
  pcileech_mux_rr #(.RR_MODE(0)) u_fp (.clk(clk), .rst(rst), .dout(d1), .valid(v1), .rd_en(rd_en),
    .din(din), .ctx(ctx), .wr_en(wr_en), .has_data(has_data), .req_data(q1), .collision(c1));
  pcileech_mux_rr #(.WORDS(3), .TIMEOUT(3), .RR_MODE(1)) u_w3 (.clk(clk), .rst(rst), .dout(d2),
    .valid(v2), .rd_en(rd_en), .din(din), .ctx(ctx), .wr_en(wr_en), .has_data(has_data),
    .req_data(q2), .collision(c2));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one entry per instance above.
  int p_w[3]  = '{7, 7, 3};
  int p_to[3] = '{8, 8, 3};
  int p_rr[3] = '{1, 0, 1};
  int m_cnt[3], m_idle[3], m_ptr[3];
  logic [31:0]  m_fw[3][7];
  logic [3:0]   m_ft[3][7];
  logic [255:0] e_dout[3];
  logic         e_valid[3], e_coll[3];
  logic [3:0]   e_req[3];
  int           vcnt[3];
  logic [255:0] lastd[3];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_cnt[c] = 0; m_idle[c] = 0; m_ptr[c] = 0;
      e_dout[c] = '0; e_valid[c] = 1'b0; e_coll[c] = 1'b0; e_req[c] = '0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      logic         acc;
      logic         fill;
      logic [31:0]  word;
      logic [3:0]   tag;
      logic [31:0]  st;
      logic [255:0] f;
      int           w;
      w = p_w[c];
      e_req[c] = 4'd0;
      if (rd_en) begin
        for (int o = 0; o < 4; o++) begin
          int p = ((p_rr[c] != 0 ? m_ptr[c] : 0) + o) % 4;
          if (has_data[p]) begin
            e_req[c] = 4'd1 << p;
            if (p_rr[c] != 0) m_ptr[c] = (p + 1) % 4;
            break;
          end
        end
      end
      if ($countones(wr_en) > 1) e_coll[c] = 1'b1;
      acc = 1'b0; word = '0; tag = '0;
      for (int k = 0; k < 4; k++) begin
        if (wr_en[k]) begin
          word = din[32*k +: 32]; tag = {ctx[2*k +: 2], 2'(k)}; acc = 1'b1;
          break;
        end
      end
      fill = !acc && m_cnt[c] > 0 && m_idle[c] >= p_to[c];
      if (m_cnt[c] > 0 && !acc) m_idle[c] = (m_idle[c] == 15) ? 15 : m_idle[c] + 1;
      if (fill) begin word = 32'hFFFF_FFFF; tag = 4'hF; end
      e_valid[c] = 1'b0;
      if (acc || fill) begin
        m_fw[c][m_cnt[c]] = word;
        m_ft[c][m_cnt[c]] = tag;
        m_cnt[c]++;
        if (m_cnt[c] == w) begin
          f = '0;
          st = 32'hEFFF_FFFF;
          for (int k = 0; k < w; k++) begin
            f[32*k +: 32] = m_fw[c][w-1-k];
            st[4*k +: 4]  = m_ft[c][w-1-k];
          end
          f[32*w +: 32] = st;
          e_dout[c] = f; e_valid[c] = 1'b1;
          m_cnt[c] = 0; m_idle[c] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [255:0] od[3];
    logic         ov[3], oc[3];
    logic [3:0]   oq[3];
    od[0] = d0; od[1] = d1; od[2] = {128'd0, d2};
    ov[0] = v0; ov[1] = v1; ov[2] = v2;
    oc[0] = c0; oc[1] = c1; oc[2] = c2;
    oq[0] = q0; oq[1] = q1; oq[2] = q2;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("valid[%0d]", c), ov[c], e_valid[c]);
      chk($sformatf("req[%0d]", c), oq[c], e_req[c]);
      chk($sformatf("coll[%0d]", c), oc[c], e_coll[c]);
      chk($sformatf("dout[%0d]", c), od[c], e_dout[c]);
      if (ov[c]) begin vcnt[c]++; lastd[c] = od[c]; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = '0; has_data = '0; rd_en = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) vcnt[c] = 0;
  endtask

  task automatic set_word(input int p, input logic [31:0] d, input logic [1:0] cx);
    wr_en = 4'd1 << p;
    din[32*p +: 32] = d;
    ctx[2*p +: 2] = cx;
  endtask

  task automatic idle(input int n);
    wr_en = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] rr_seq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // Arbitration order, round-robin versus fixed priority
    do_reset();
    has_data = 4'hF; rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_seq", q0, rr_seq[i]);
      chk("fp_seq", q1, 4'b0001);
    end

    // Full default frame from port 1
    do_reset();
    for (int i = 1; i <= 7; i++) begin set_word(1, 32'(i), 2'd2); tick(); end
    idle(2);
    chk("f34_cnt", vcnt[0], 1);
    chk("f34_lo", lastd[0][31:0], 32'h7);
    chk("f34_hi", lastd[0][223:192], 32'h1);
    chk("f34_st", lastd[0][255:224], 32'hE999_9999);

    // Partial frame padded after the idle timeout
    do_reset();
    for (int i = 0; i < 3; i++) begin set_word(0, 32'h100 + 32'(i), 2'd1); tick(); end
    idle(11);
    chk("f36_early", vcnt[0], 0);
    idle(3);
    chk("f36_cnt", vcnt[0], 1);
    chk("f36_fill", lastd[0][127:0], {128{1'b1}});
    chk("f36_real", lastd[0][159:128], 32'h102);
    chk("f36_st", lastd[0][255:224], 32'hE444_FFFF);

    // Simultaneous writers
    do_reset();
    wr_en = 4'b0110;
    din[63:32] = 32'hAAAA_0001; ctx[3:2] = 2'd3;
    din[95:64] = 32'hBBBB_0002; ctx[5:4] = 2'd0;
    tick();
    chk("f37_coll", c0, 1'b1);
    for (int i = 0; i < 6; i++) begin set_word(1, 32'h50 + 32'(i), 2'd0); tick(); end
    idle(3);
    chk("f37_sticky", c0, 1'b1);
    chk("f37_cnt", vcnt[0], 1);
    chk("f37_old", lastd[0][223:192], 32'hAAAA_0001);

    // Three-word frame
    do_reset();
    for (int i = 0; i < 3; i++) begin set_word(3, 32'h30 + 32'(i), 2'd0); tick(); end
    idle(1);
    chk("f38_cnt", vcnt[2], 1);
    chk("f38_st", lastd[2][127:96], 32'hEFFF_F333);
    chk("f38_new", lastd[2][31:0], 32'h32);

    // Reset in the middle of a frame
    do_reset();
    for (int i = 0; i < 4; i++) begin set_word(2, 32'hDEAD_0000 + 32'(i), 2'd1); tick(); end
    do_reset();
    for (int i = 0; i < 7; i++) begin set_word(0, 32'hC0 + 32'(i), 2'd3); tick(); end
    idle(20);
    chk("f39_cnt", vcnt[0], 1);
    chk("f39_old", lastd[0][223:192], 32'hC0);
    chk("f39_new", lastd[0][31:0], 32'hC6);

    // Randomized traffic against the model
    for (int seg = 0; seg < 12; seg++) begin
      bit sparse;
      if (seg % 4 == 0) do_reset();
      sparse = ($urandom % 2) == 1;
      for (int i = 0; i < 64; i++) begin
        int r;
        rd_en = ($urandom % 4) != 0;
        has_data = 4'($urandom);
        din = {$urandom, $urandom, $urandom, $urandom};
        ctx = 8'($urandom);
        r = $urandom % 16;
        if (sparse ? (r < 13) : (r < 4)) wr_en = '0;
        else if (r == 15) wr_en = 4'($urandom);
        else wr_en = 4'd1 << ($urandom % 4);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
